// File: rtl/rv32_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : rv32_muldiv_seq
// Purpose  : Iterative sequencer for RV32 M-extension ops. It runs a radix-2
//            shift-add multiply or a restoring divide over one shared
//            (2*WIDTH+1)-bit accumulator, one iteration per clock.
//            Divide-by-zero and signed overflow finish on the accept edge.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            i_flush           - abort op in flight (highest priority)
//            i_valid/o_ready   - request handshake (o_ready high only in IDLE)
//            i_funct3          - MUL..REMU selector
//            i_rs1/i_rs2/i_rd  - operands and destination tag
//            o_valid/i_ready   - result handshake
//            o_result/o_rd     - result word and its tag
//            o_busy            - high whenever not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module rv32_muldiv_seq #(
    parameter int WIDTH          = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_flush,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [2:0]                i_funct3,
    input  logic [WIDTH-1:0]          i_rs1,
    input  logic [WIDTH-1:0]          i_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [WIDTH-1:0]          o_result,
    output logic [REG_ADDR_WIDTH-1:0] o_rd,
    output logic                      o_busy
);

    localparam int c_ACC_W = 2 * WIDTH + 1;
    localparam int c_CNT_W = $clog2(WIDTH);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [WIDTH-1:0]   c_MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [2:0] c_F3_MUL    = 3'b000;
    localparam logic [2:0] c_F3_MULH   = 3'b001;
    localparam logic [2:0] c_F3_MULHSU = 3'b010;
    localparam logic [2:0] c_F3_MULHU  = 3'b011;
    localparam logic [2:0] c_F3_DIV    = 3'b100;
    localparam logic [2:0] c_F3_DIVU   = 3'b101;
    localparam logic [2:0] c_F3_REM    = 3'b110;
    localparam logic [2:0] c_F3_REMU   = 3'b111;

    // Registered state
    logic [1:0]                r_state_q,  w_state_d;
    logic [c_CNT_W-1:0]        r_count_q,  w_count_d;
    logic [c_ACC_W-1:0]        r_acc_q,    w_acc_d;
    logic [WIDTH-1:0]          r_opb_q,    w_opb_d;
    logic [2:0]                r_funct3_q, w_funct3_d;
    logic [REG_ADDR_WIDTH-1:0] r_rd_q,     w_rd_d;
    logic                      r_neg_q,    w_neg_d;
    logic                      r_rem_neg_q, w_rem_neg_d;
    logic [WIDTH-1:0]          r_result_q, w_result_d;
    logic                      r_valid_q,  w_valid_d;

    // Accept-time decode
    logic             w_rs1_signed, w_rs2_signed;
    logic             w_rs1_neg, w_rs2_neg;
    logic [WIDTH-1:0] w_rs1_mag, w_rs2_mag;
    logic             w_div_zero, w_div_ovf;

    // Iteration datapath
    logic [WIDTH:0]       w_mul_sum;
    logic [c_ACC_W-1:0]   w_mul_step;
    logic [c_ACC_W-1:0]   w_div_shift;
    logic [WIDTH:0]       w_div_trial;
    logic [c_ACC_W-1:0]   w_div_step;
    logic [c_ACC_W-1:0]   w_acc_iter;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quot, w_rem;
    logic [WIDTH-1:0]     w_final;

    always_comb begin
        w_rs1_signed = (i_funct3 == c_F3_MULH) || (i_funct3 == c_F3_MULHSU) ||
                       (i_funct3 == c_F3_DIV)  || (i_funct3 == c_F3_REM);
        w_rs2_signed = (i_funct3 == c_F3_MULH) || (i_funct3 == c_F3_DIV) ||
                       (i_funct3 == c_F3_REM);
        w_rs1_neg    = w_rs1_signed && i_rs1[WIDTH-1];
        w_rs2_neg    = w_rs2_signed && i_rs2[WIDTH-1];
        // The most negative value maps to itself, which is the correct
        // unsigned magnitude.
        w_rs1_mag    = w_rs1_neg ? ('0 - i_rs1) : i_rs1;
        w_rs2_mag    = w_rs2_neg ? ('0 - i_rs2) : i_rs2;
        w_div_zero   = i_funct3[2] && (i_rs2 == '0);
        w_div_ovf    = i_funct3[2] && !i_funct3[0] &&
                       (i_rs1 == c_MIN_NEG) && (&i_rs2);
    end

    always_comb begin
        // Multiply: low half holds the remaining multiplier bits, upper
        // half (plus carry bit) accumulates the partial product.
        w_mul_sum   = {1'b0, r_acc_q[2*WIDTH-1:WIDTH]} + {1'b0, r_opb_q};
        w_mul_step  = r_acc_q[0] ? ({w_mul_sum, r_acc_q[WIDTH-1:0]} >> 1)
                                 : (r_acc_q >> 1);

        // Divide: {rem, quot} shifted left; remainder never exceeds WIDTH
        // bits, so the acc MSB is always zero here.
        w_div_shift = {r_acc_q[2*WIDTH-1:0], 1'b0};
        w_div_trial = w_div_shift[2*WIDTH:WIDTH] - {1'b0, r_opb_q};
        w_div_step  = w_div_trial[WIDTH] ? w_div_shift
                                         : {w_div_trial, w_div_shift[WIDTH-1:1], 1'b1};

        w_acc_iter  = r_funct3_q[2] ? w_div_step : w_mul_step;

        // Sign fixup: the full 64-bit product is negated so the high word
        // borrows correctly from the low word.
        w_prod_fix  = r_neg_q ? ('0 - w_acc_iter[2*WIDTH-1:0]) : w_acc_iter[2*WIDTH-1:0];
        w_quot      = r_neg_q ? ('0 - w_acc_iter[WIDTH-1:0]) : w_acc_iter[WIDTH-1:0];
        w_rem       = r_rem_neg_q ? ('0 - w_acc_iter[2*WIDTH-1:WIDTH])
                                  : w_acc_iter[2*WIDTH-1:WIDTH];

        case (r_funct3_q)
            c_F3_MUL:                          w_final = w_prod_fix[WIDTH-1:0];
            c_F3_MULH, c_F3_MULHSU, c_F3_MULHU: w_final = w_prod_fix[2*WIDTH-1:WIDTH];
            c_F3_DIV, c_F3_DIVU:               w_final = w_quot;
            c_F3_REM, c_F3_REMU:               w_final = w_rem;
            default:                           w_final = w_quot;
        endcase
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_count_d   = r_count_q;
        w_acc_d     = r_acc_q;
        w_opb_d     = r_opb_q;
        w_funct3_d  = r_funct3_q;
        w_rd_d      = r_rd_q;
        w_neg_d     = r_neg_q;
        w_rem_neg_d = r_rem_neg_q;
        w_result_d  = r_result_q;
        w_valid_d   = r_valid_q;

        if (i_flush) begin
            w_state_d = c_IDLE;
            w_valid_d = 1'b0;
        end else begin
            case (r_state_q)
                c_IDLE: begin
                    if (i_valid) begin
                        w_funct3_d  = i_funct3;
                        w_rd_d      = i_rd;
                        w_opb_d     = w_rs2_mag;
                        w_neg_d     = w_rs1_neg ^ w_rs2_neg;
                        w_rem_neg_d = w_rs1_neg;
                        w_acc_d     = {{(WIDTH+1){1'b0}}, w_rs1_mag};
                        w_count_d   = '0;
                        if (w_div_zero) begin
                            w_result_d = i_funct3[1] ? i_rs1 : '1;
                            w_state_d  = c_DONE;
                            w_valid_d  = 1'b1;
                        end else if (w_div_ovf) begin
                            w_result_d = i_funct3[1] ? '0 : c_MIN_NEG;
                            w_state_d  = c_DONE;
                            w_valid_d  = 1'b1;
                        end else begin
                            w_state_d  = c_CALC;
                        end
                    end
                end
                c_CALC: begin
                    w_acc_d   = w_acc_iter;
                    w_count_d = r_count_q + c_CNT_ONE;
                    if (r_count_q == c_CNT_LAST) begin
                        w_result_d = w_final;
                        w_state_d  = c_DONE;
                        w_valid_d  = 1'b1;
                    end
                end
                c_DONE: begin
                    if (i_ready) begin
                        w_state_d = c_IDLE;
                        w_valid_d = 1'b0;
                    end
                end
                default: begin
                    w_state_d = c_IDLE;
                    w_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q   <= c_IDLE;
            r_count_q   <= '0;
            r_acc_q     <= '0;
            r_opb_q     <= '0;
            r_funct3_q  <= '0;
            r_rd_q      <= '0;
            r_neg_q     <= 1'b0;
            r_rem_neg_q <= 1'b0;
            r_result_q  <= '0;
            r_valid_q   <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_count_q   <= w_count_d;
            r_acc_q     <= w_acc_d;
            r_opb_q     <= w_opb_d;
            r_funct3_q  <= w_funct3_d;
            r_rd_q      <= w_rd_d;
            r_neg_q     <= w_neg_d;
            r_rem_neg_q <= w_rem_neg_d;
            r_result_q  <= w_result_d;
            r_valid_q   <= w_valid_d;
        end
    end

    assign o_ready  = (r_state_q == c_IDLE);
    assign o_busy   = (r_state_q != c_IDLE);
    assign o_valid  = r_valid_q;
    assign o_result = r_result_q;
    assign o_rd     = r_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_muldiv_seq
// Purpose  : Self-checking bench for rv32_muldiv_seq: directed vector table,
//            randomized ops against an arithmetic reference model, and
//            hand-written backpressure / flush / reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_funct3;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic [4:0]  i_rd;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic [4:0]  o_rd;
    logic        o_busy;

    int checks;
    int failures;

    rv32_muldiv_seq #(.WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_flush  (i_flush),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_funct3 (i_funct3),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_rd     (i_rd),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_rd     (o_rd),
        .o_busy   (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model straight from the M-extension arithmetic rules.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        int          sia, sib;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = {32'b0, b};
        sia = a;
        sib = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return sia / sib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return sia % sib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, wait for its result, check latency/result/tag, accept it.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input string name);
        int   lat;
        int   exp_lat;
        logic special;
        special = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        exp_lat = special ? 1 : 33;
        chk({name, "_ready"}, {31'b0, o_ready}, 32'd1);
        i_funct3 = f3; i_rs1 = a; i_rs2 = b; i_rd = rd;
        i_valid  = 1'b1;
        i_ready  = 1'b0;
        @(posedge clk); #1;
        i_valid  = 1'b0;
        // Scramble inputs; only the accept edge may sample them.
        i_rs1 = $urandom; i_rs2 = $urandom; i_funct3 = 3'($urandom); i_rd = 5'($urandom);
        lat = 1;
        while (!o_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_result"}, o_result, exp);
        chk({name, "_rd"}, {27'b0, o_rd}, {27'b0, rd});
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        chk({name, "_valid_drop"}, {31'b0, o_valid}, 32'd0);
    endtask

    vec_t vecs[14];

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [4:0]  rd;
        int          seen;

        checks   = 0;
        failures = 0;

        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         5'd11, 32'd14};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         5'd12, 32'd2};
        vecs[8]  = '{3'd5, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF};
        vecs[9]  = '{3'd6, 32'd5,         32'd0,         5'd14, 32'd5};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0};
        vecs[12] = '{3'd0, 32'd3,         32'd4,         5'd17, 32'd12};
        vecs[13] = '{3'd7, 32'hFFFF_FFF9, 32'd0,         5'd31, 32'hFFFF_FFF9};

        rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_funct3 = '0; i_rs1 = '0; i_rs2 = '0; i_rd = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("rst_ready",  {31'b0, o_ready}, 32'd1);
        chk("rst_valid",  {31'b0, o_valid}, 32'd0);
        chk("rst_busy",   {31'b0, o_busy},  32'd0);
        chk("rst_result", o_result,          32'd0);
        chk("rst_rd",     {27'b0, o_rd},     32'd0);

        // Directed vectors
        for (int i = 0; i < 14; i++)
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, $sformatf("vec%0d", i));

        // Randomized ops vs reference model
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom);
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom);
            run_op(f3, a, b, rd, ref_model(f3, a, b), $sformatf("rnd%0d_f%0d", i, f3));
        end

        // Backpressure: hold result in DONE for 10 cycles
        i_funct3 = 3'd5; i_rs1 = 32'd100; i_rs2 = 32'd7; i_rd = 5'd9; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        seen = 0;
        while (!o_valid && seen < 100) begin @(posedge clk); #1; seen++; end
        chk("bp_valid_seen", {31'b0, o_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_valid",  {31'b0, o_valid}, 32'd1);
            chk("bp_hold_result", o_result,          32'd14);
            chk("bp_hold_rd",     {27'b0, o_rd},     32'd9);
            chk("bp_hold_ready",  {31'b0, o_ready}, 32'd0);
            @(posedge clk); #1;
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        chk("bp_idle_valid", {31'b0, o_valid}, 32'd0);
        chk("bp_idle_ready", {31'b0, o_ready}, 32'd1);
        i_funct3 = 3'd0; i_rs1 = 32'd2; i_rs2 = 32'd3; i_rd = 5'd1; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("bp_next_accept", {31'b0, o_busy}, 32'd1);
        seen = 0;
        while (!o_valid && seen < 100) begin @(posedge clk); #1; seen++; end
        chk("bp_next_result", o_result, 32'd6);
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;

        // Flush at count=10
        i_funct3 = 3'd1; i_rs1 = 32'h1234_5678; i_rs2 = 32'h9ABC_DEF0; i_rd = 5'd20; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        chk("flush_ready", {31'b0, o_ready}, 32'd1);
        chk("flush_busy",  {31'b0, o_busy},  32'd0);
        chk("flush_valid", {31'b0, o_valid}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_valid) seen++;
            @(posedge clk); #1;
        end
        chk("flush_no_valid", seen, 32'd0);
        run_op(3'd0, 32'd3, 32'd4, 5'd3, 32'd12, "post_flush_mul");

        // Flush together with i_valid in IDLE: no accept
        i_funct3 = 3'd0; i_rs1 = 32'd5; i_rs2 = 32'd5; i_rd = 5'd2;
        i_valid = 1'b1; i_flush = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        chk("flush_valid_busy",  {31'b0, o_busy},  32'd0);
        chk("flush_valid_ready", {31'b0, o_ready}, 32'd1);

        // Flush in DONE beats a simultaneous i_ready
        i_funct3 = 3'd5; i_rs1 = 32'd9; i_rs2 = 32'd0; i_rd = 5'd4; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("flush_done_valid_pre", {31'b0, o_valid}, 32'd1);
        i_flush = 1'b1; i_ready = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0; i_ready = 1'b0;
        chk("flush_done_valid", {31'b0, o_valid}, 32'd0);
        chk("flush_done_ready", {31'b0, o_ready}, 32'd1);

        // Rebuild a nonzero stale result, then assert async reset mid-CALC
        run_op(3'd0, 32'd3, 32'd4, 5'd3, 32'd12, "pre_reset_mul");
        i_funct3 = 3'd4; i_rs1 = 32'd1000; i_rs2 = 32'd3; i_rd = 5'd21; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("amid_rst_ready",  {31'b0, o_ready}, 32'd1);
        chk("amid_rst_valid",  {31'b0, o_valid}, 32'd0);
        chk("amid_rst_busy",   {31'b0, o_busy},  32'd0);
        chk("amid_rst_result", o_result,          32'd0);
        chk("amid_rst_rd",     {27'b0, o_rd},     32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(3'd4, 32'd1000, 32'd3, 5'd21, 32'd333, "post_reset_div");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
